// File: rtl/imem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory port arbiter.
// Owner encoding tracks which requester the next cycle's read data belongs to.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  localparam int WORD_OFF_BITS = 2;
  localparam int ADDR_MAX_W    = 64;

  // Word index of a byte address; callers truncate to their depth.
  function automatic logic [ADDR_MAX_W-1:0] word_idx(
    input logic [ADDR_MAX_W-1:0] addr
  );
    return addr >> WORD_OFF_BITS;
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while fetch is waiting.
// at_max_o tells the arbiter to hand the next grant to fetch.
module arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign at_max_o = (cnt_q == CW'(STARVE_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-port word memory between fetch and load/store.
// Data wins contention unless fetch has been starved STARVE_MAX times.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_misalign,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  logic                  at_max;
  logic [DEPTH_LOG2-1:0] i_widx;
  logic [DEPTH_LOG2-1:0] d_widx;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DEPTH_LOG2-1:0] addr_d;
  owner_t                owner_q;
  owner_t                owner_d;

  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset) begin
      if (d_req && !(i_req && at_max)) begin
        d_gnt = 1'b1;
      end else if (i_req) begin
        i_gnt = 1'b1;
      end
    end
  end

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (d_gnt & i_req),
    .clr_i   (i_gnt | ~i_req),
    .at_max_o(at_max)
  );

  assign i_widx = DEPTH_LOG2'(word_idx(ADDR_MAX_W'(i_addr)));
  assign d_widx = DEPTH_LOG2'(word_idx(ADDR_MAX_W'(d_addr)));

  // Idle cycles keep presenting the last granted address.
  always_comb begin
    mem_addr = addr_q;
    if (d_gnt) begin
      mem_addr = d_widx;
    end else if (i_gnt) begin
      mem_addr = i_widx;
    end
  end

  assign addr_d     = mem_addr;
  assign mem_we     = d_gnt & d_we;
  assign mem_wdata  = d_wdata;
  assign d_misalign = d_gnt & (|d_addr[WORD_OFF_BITS-1:0]);

  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      i_gnt:           owner_d = OWN_I;
      (d_gnt & ~d_we): owner_d = OWN_D;
      default:         owner_d = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
    end
  end

  // Reset kills a read still in flight from the cycle before.
  assign i_rvalid = ~reset & (owner_q == OWN_I);
  assign d_rvalid = ~reset & (owner_q == OWN_D);
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed vector table, corner sequences
// and random traffic against a request-level reference model.
module tb_imem_port_arbiter;

  localparam int SM    = 4;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_misalign;
  logic [5:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .DEPTH_LOG2(6),
    .STARVE_MAX(SM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_misalign(d_misalign),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(input int k);
    return 32'hA5A50000 ^ (32'(k) * 32'h01010101);
  endfunction

  logic [31:0] ram [DEPTH];

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: request-level view of the port.
  int          starve;
  int          pend;
  logic [31:0] pend_data;
  int          last_addr;
  logic [31:0] shadow [DEPTH];

  logic        s_ig, s_dg, s_mis, s_we, s_irv, s_drv;
  logic [5:0]  s_ma;
  logic [31:0] s_rd;

  task automatic apply(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dwd,
                       input logic rst);
    logic        eig, edg;
    logic [31:0] ba;
    int          idx;
    reset = rst; i_req = ir; i_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    s_ig = i_gnt; s_dg = d_gnt; s_mis = d_misalign; s_we = mem_we;
    s_ma = mem_addr; s_irv = i_rvalid; s_drv = d_rvalid;
    s_rd = i_rvalid ? i_rdata : d_rdata;
    edg = !rst && dr && !(ir && starve == SM);
    eig = !rst && ir && !edg;
    ba  = eig ? ia : da;
    idx = int'((ba >> 2) % DEPTH);
    chk("i_gnt", i_gnt, eig);
    chk("d_gnt", d_gnt, edg);
    chk("mem_we", mem_we, edg && dwe);
    chk("d_misalign", d_misalign, edg && (da % 4 != 0));
    if (eig || edg) chk("mem_addr", mem_addr, idx);
    else if (!rst && last_addr >= 0) chk("mem_addr_hold", mem_addr, last_addr);
    if (edg && dwe) chk("mem_wdata", mem_wdata, dwd);
    chk("i_rvalid", i_rvalid, !rst && pend == 1);
    chk("d_rvalid", d_rvalid, !rst && pend == 2);
    if (!rst && pend == 1) chk("i_rdata", i_rdata, pend_data);
    if (!rst && pend == 2) chk("d_rdata", d_rdata, pend_data);
    if (rst) begin
      starve = 0; pend = 0; last_addr = -1;
    end else begin
      pend = 0;
      if (eig || edg) begin
        last_addr = idx;
        pend_data = shadow[idx];
        if (eig) pend = 1;
        else if (!dwe) pend = 2;
        if (edg && dwe) shadow[idx] = dwd;
      end
      starve = (ir && edg) ? ((starve + 1 > SM) ? SM : starve + 1) : 0;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        ig;
    logic        dg;
    logic [5:0]  ma;
    logic        mis;
    logic        we;
    logic        irv;
    logic        drv;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [13];

  initial begin
    for (int k = 0; k < DEPTH; k++) begin
      ram[k]    = init_val(k);
      shadow[k] = init_val(k);
    end
    starve = 0; pend = 0; last_addr = -1; pend_data = '0;
    reset = 1'b1; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    tv[0]  = '{1'b1, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,
               1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[1]  = '{1'b1, 32'h4,   1'b0, 1'b0, 32'h0,  32'h0,
               1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 1'b1, 1'b0, init_val(0)};
    tv[2]  = '{1'b1, 32'h8,   1'b0, 1'b0, 32'h0,  32'h0,
               1'b1, 1'b0, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, init_val(1)};
    tv[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h10, 32'hDEADBEEF,
               1'b0, 1'b1, 6'd4, 1'b0, 1'b1, 1'b1, 1'b0, init_val(2)};
    tv[4]  = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10, 32'h0,
               1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[5]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,
               1'b0, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF};
    tv[6]  = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,
               1'b0, 1'b0, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[7]  = tv[6];
    tv[8]  = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,  32'h0,
               1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h13, 32'h12345678,
               1'b0, 1'b1, 6'd4, 1'b1, 1'b1, 1'b1, 1'b0, init_val(0)};
    tv[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h10, 32'h0,
               1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    tv[11] = '{1'b1, 32'h40,  1'b1, 1'b0, 32'h20, 32'h0,
               1'b0, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678};
    tv[12] = '{1'b0, 32'h0,   1'b0, 1'b0, 32'h0,  32'h0,
               1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0, 1'b1, init_val(8)};

    @(posedge clk);
    #1;
    // Reset held with both requesters active: nothing may be granted.
    apply(1'b1, 32'h4, 1'b1, 1'b1, 32'h8, 32'h1, 1'b1);
    apply(1'b1, 32'h4, 1'b1, 1'b0, 32'h8, 32'h1, 1'b1);

    for (int i = 0; i < 13; i++) begin
      apply(tv[i].ir, tv[i].ia, tv[i].dr, tv[i].dwe, tv[i].da, tv[i].dwd,
            1'b0);
      chk("tv_i_gnt", s_ig, tv[i].ig);
      chk("tv_d_gnt", s_dg, tv[i].dg);
      chk("tv_mem_addr", s_ma, tv[i].ma);
      chk("tv_misalign", s_mis, tv[i].mis);
      chk("tv_mem_we", s_we, tv[i].we);
      chk("tv_i_rvalid", s_irv, tv[i].irv);
      chk("tv_d_rvalid", s_drv, tv[i].drv);
      if (tv[i].irv || tv[i].drv) chk("tv_rdata", s_rd, tv[i].rd);
    end

    // Contention: fetch only wins every fifth cycle.
    for (int k = 0; k < 10; k++) begin
      apply(1'b1, 32'h40, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
      chk("starve_pattern", s_ig, (k % 5) == 4);
    end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Reset arriving while a fetch read is in flight.
    apply(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_pre_gnt", s_ig, 1'b1);
    apply(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    chk("rst_kill_rvalid", s_irv, 1'b0);
    chk("rst_no_gnt", s_ig | s_dg, 1'b0);
    apply(1'b1, 32'h8, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1);
    apply(1'b1, 32'hC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_resume_gnt", s_ig, 1'b1);
    chk("rst_resume_addr", s_ma, 6'd3);
    apply(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("rst_resume_rvalid", s_irv, 1'b1);

    // Random traffic, including withdrawn requests and wrapped addresses.
    for (int k = 0; k < 400; k++) begin
      apply(1'($urandom_range(0, 1)), 32'($urandom_range(0, 511)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 511)), $urandom,
            ($urandom_range(0, 49) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
